bist_response_checker: RTL and testbench
========================================

Name: bist_response_checker

Overview:
- Response analyzer on the read side of the memory BIST march. The march controller drives the memory and issues read strobes with an expected background bit.
- This block receives the memory read data returned RD_LAT cycles later and compares it against the expected pattern.
- It counts mismatches, captures the first failing address and its syndrome, and raises done/status once the controller signals that the march has finished.

Parameters:
- ADDR_W, 4: memory address width.
- DATA_W, 8: memory word width; the expected word is data_bit replicated DATA_W times.
- RD_LAT, 1: memory read latency in clk cycles, from read_en to valid rd_data. Legal range 1..4.
- ERR_W, 8: error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears all results and arms checking.
- read_en  in  1  controller read strobe; address and expected bit are valid this cycle.
- data_bit  in  1  expected background bit for this read.
- addr  in  ADDR_W  address of this read.
- rd_data  in  DATA_W  memory read data; valid RD_LAT cycles after read_en.
- test_end  in  1  one-cycle pulse from the controller when the final march element completes.
- done  out  1  high while in DONE.
- status  out  1  1 = pass; meaningful only when done=1.
- fail  out  1  sticky; set on the first mismatch since start.
- err_cnt  out  ERR_W  mismatch count, saturating.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_syn  out  DATA_W  rd_data XOR expected word at the first mismatch.

Behaviour:
- Reset (rst=0, async): state=IDLE. done=0, status=0, fail=0, err_cnt=0, fail_addr=0, fail_syn=0. All pipeline valid bits are 0.
- Alignment pipeline: RD_LAT stages carry {valid=read_en & armed, addr, data_bit}.
  - Stage RD_LAT output is compared against rd_data in the same cycle.
  - armed = 1 in CHECK and DRAIN.
- Compare: mismatch = pipe_valid & (rd_data != {DATA_W{pipe_bit}}). Results are registered one cycle after the compare cycle.
- On mismatch:
  - err_cnt increments by 1, saturating at 2^ERR_W-1 (no wrap).
  - If fail was 0: fail=1, fail_addr=pipe_addr, fail_syn=rd_data^expected. Later mismatches never overwrite these fields.
- States:
  - IDLE: outputs hold. read_en is ignored. start -> CHECK.
  - CHECK: read_en enters the pipeline. test_end -> DRAIN. start -> CHECK, with results cleared and the pipeline flushed.
  - DRAIN: no new entries; reads in flight are still compared. After RD_LAT cycles -> DONE. This lets the last read, issued in the test_end cycle, be checked.
  - DONE: done=1, status=(err_cnt==0) evaluated after the final compare has registered. Outputs hold. read_en is ignored. start -> CHECK.
- start in any state:
  - Next cycle: err_cnt=0, fail=0, fail_addr=0, fail_syn=0, done=0, status=0. The pipeline is flushed, so in-flight reads are discarded.
  - read_en asserted in the same cycle as start is accepted into the fresh test.
- Simultaneous start and test_end: start wins; next state is CHECK.
- test_end outside CHECK is ignored.
- read_en and test_end in the same cycle: the read is accepted and checked during DRAIN.
- Latency: test_end pulse to done=1 is RD_LAT+1 cycles.
- rst asserted mid-march: immediate async clear to the reset values above. A new start is required afterwards.

Test Plan:
- Clean march (DATA_W=8, RD_LAT=1): start; 16 reads over addr 0..15 with data_bit=0 and rd_data=0x00, then 16 reads with data_bit=1 and rd_data=0xFF; test_end -> done=1 two cycles later, status=1, fail=0, err_cnt=0.
- Single fault: as above, but rd_data=0xF7 for the data_bit=1 read of addr 5 -> fail=1, fail_addr=5, fail_syn=0x08, err_cnt=1, status=0.
- Multiple faults: mismatches at addr 3 then addr 9 -> fail_addr=3 (first retained), err_cnt=2.
- Saturation (ERR_W=2): 5 mismatching reads -> err_cnt=3, status=0.
- Last-read drain (RD_LAT=3): read_en at addr 15 in the same cycle as test_end, with a corrupted rd_data 3 cycles later -> fail_addr=15, err_cnt=1, done rises 4 cycles after test_end.
- Restart and reset: start in DONE with fail=1 -> all results clear next cycle. rst=0 pulse mid-CHECK -> outputs 0 immediately; a read_en with mismatching data after rst returns high, without a start, is not counted.

Source files
------------

// File: rtl/bist_response_checker.sv
// bist_response_checker: compares BIST read data against the expected background,
// counts mismatches and captures the first failing address and syndrome.
module bist_response_checker #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              read_en,
   input  logic              data_bit,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              test_end,
   output logic              done,
   output logic              status,
   output logic              fail,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_syn
);
   typedef enum logic [1:0] {IDLE, CHECK, DRAIN, DONE} state_t;
   state_t            r_state;
   logic [RD_LAT-1:0] r_pv, r_pb;
   logic [ADDR_W-1:0] r_pa [RD_LAT];
   logic [2:0]        r_dcnt;
   logic              w_accept, w_mis, w_last;
   logic [DATA_W-1:0] w_syn;
   logic [ERR_W-1:0]  w_err_nxt;
   // a read issued alongside start belongs to the fresh test
   assign w_accept  = read_en & (start | (r_state == CHECK));
   assign w_syn     = rd_data ^ {DATA_W{r_pb[RD_LAT-1]}};
   assign w_mis     = r_pv[RD_LAT-1] & (w_syn != '0);
   assign w_err_nxt = (w_mis && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;
   assign w_last    = (r_state == DRAIN) && (r_dcnt == 3'(RD_LAT-1));
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pv <= '0;
         r_pb <= '0;
         for (int i = 0; i < RD_LAT; i++) r_pa[i] <= '0;
      end else begin
         r_pv[0] <= w_accept;
         r_pb[0] <= data_bit;
         r_pa[0] <= addr;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1] & ~start;
            r_pb[i] <= r_pb[i-1];
            r_pa[i] <= r_pa[i-1];
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_dcnt    <= '0;
         done      <= 1'b0;
         status    <= 1'b0;
         fail      <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
         fail_syn  <= '0;
      end else if (start) begin
         r_state   <= CHECK;
         r_dcnt    <= '0;
         done      <= 1'b0;
         status    <= 1'b0;
         fail      <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
         fail_syn  <= '0;
      end else begin
         err_cnt <= w_err_nxt;
         if (w_mis && !fail) begin
            fail      <= 1'b1;
            fail_addr <= r_pa[RD_LAT-1];
            fail_syn  <= w_syn;
         end
         case (r_state)
            CHECK: if (test_end) begin
               r_state <= DRAIN;
               r_dcnt  <= '0;
            end
            // status folds in the compare registering on this same edge
            DRAIN: if (w_last) begin
               r_state <= DONE;
               done    <= 1'b1;
               status  <= (w_err_nxt == '0);
            end else r_dcnt <= r_dcnt + 3'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bist_response_checker.sv
// tb_bist_response_checker: scoreboard bench driving an RD_LAT=1 and an RD_LAT=3/ERR_W=2
// instance with the same march; expected results are checked when done rises.
module tb_bist_response_checker;
   typedef struct {
      logic       status;
      logic       fail;
      logic [7:0] err;
      logic [3:0] addr;
      logic [7:0] syn;
      int         lat;
   } exp_t;
   logic       clk = 0, rst_n = 0, start = 0, read_en = 0, data_bit = 0, test_end = 0;
   logic [3:0] addr = 0;
   logic [7:0] mem_q = 0, d1 = 0, d2 = 0, d3 = 0;
   logic       done_a, status_a, fail_a, done_c, status_c, fail_c;
   logic [7:0] err_a, syn_a, syn_c;
   logic [1:0] err_c;
   logic [3:0] fa_a, fa_c;
   int         checks = 0, failures = 0, cyc = 0, te_cyc = 0;
   logic       pd_a = 0, pd_c = 0;
   exp_t       q_a[$], q_c[$];
   exp_t       ea, ec;

   bist_response_checker #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .ERR_W(8)) u_a (
      .clk(clk), .rst(rst_n), .start(start), .read_en(read_en), .data_bit(data_bit),
      .addr(addr), .rd_data(d1), .test_end(test_end), .done(done_a), .status(status_a),
      .fail(fail_a), .err_cnt(err_a), .fail_addr(fa_a), .fail_syn(syn_a));
   bist_response_checker #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .ERR_W(2)) u_c (
      .clk(clk), .rst(rst_n), .start(start), .read_en(read_en), .data_bit(data_bit),
      .addr(addr), .rd_data(d3), .test_end(test_end), .done(done_c), .status(status_c),
      .fail(fail_c), .err_cnt(err_c), .fail_addr(fa_c), .fail_syn(syn_c));

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      d1  <= mem_q;
      d2  <= d1;
      d3  <= d2;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done_a && !pd_a) begin
         if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
         else begin
            ea = q_a.pop_front();
            chk("a_status", status_a, ea.status);
            chk("a_fail", fail_a, ea.fail);
            chk("a_err_cnt", err_a, ea.err);
            chk("a_fail_addr", fa_a, ea.addr);
            chk("a_fail_syn", syn_a, ea.syn);
            chk("a_latency", cyc - te_cyc, ea.lat);
         end
      end
      if (done_c && !pd_c) begin
         if (q_c.size() == 0) chk("c_unexpected_done", 1, 0);
         else begin
            ec = q_c.pop_front();
            chk("c_status", status_c, ec.status);
            chk("c_fail", fail_c, ec.fail);
            chk("c_err_cnt", {6'd0, err_c}, ec.err);
            chk("c_fail_addr", fa_c, ec.addr);
            chk("c_fail_syn", syn_c, ec.syn);
            chk("c_latency", cyc - te_cyc, ec.lat);
         end
      end
      pd_a = done_a;
      pd_c = done_c;
   end

   task automatic drive(input logic re, input logic [3:0] a, input logic b, input logic [7:0] d,
                        input logic st, input logic te);
      @(posedge clk);
      #1;
      read_en  = re;
      addr     = a;
      data_bit = b;
      mem_q    = d;
      start    = st;
      test_end = te;
      if (te) te_cyc = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 0, 0);
   endtask

   task automatic march(input logic b, input int bad0, input logic [7:0] v0,
                        input int bad1, input logic [7:0] v1, input logic st);
      logic [7:0] d;
      for (int a = 0; a < 16; a++) begin
         d = b ? 8'hFF : 8'h00;
         if (a == bad0) d = v0;
         if (a == bad1) d = v1;
         drive(1, 4'(a), b, d, st && a == 0, 0);
      end
   endtask

   task automatic finish_test(input exp_t xa, input exp_t xc, input logic te_with_read);
      q_a.push_back(xa);
      q_c.push_back(xc);
      if (!te_with_read) drive(0, 0, 0, 8'h00, 0, 1);
      drive(0, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 30 && (q_a.size() != 0 || q_c.size() != 0); i++) @(negedge clk);
      if (q_a.size() != 0 || q_c.size() != 0) begin
         chk("done_timeout", q_a.size() + q_c.size(), 0);
         q_a.delete();
         q_c.delete();
      end
      idle(1);
   endtask

   task automatic chk_clear(input string nm);
      chk({nm, "_a"}, {done_a, status_a, fail_a, err_a, fa_a, syn_a}, 0);
      chk({nm, "_c"}, {done_c, status_c, fail_c, err_c, fa_c, syn_c}, 0);
   endtask

   initial begin
      #2;
      chk_clear("reset");
      #10 rst_n = 1;
      idle(2);
      // clean march, first read issued with start
      march(0, -1, 0, -1, 0, 1);
      march(1, -1, 0, -1, 0, 0);
      finish_test('{1, 0, 8'd0, 4'd0, 8'h00, 2}, '{1, 0, 8'd0, 4'd0, 8'h00, 4}, 0);
      // single fault at addr 5, background 1
      march(0, -1, 0, -1, 0, 1);
      march(1, 5, 8'hF7, -1, 0, 0);
      finish_test('{0, 1, 8'd1, 4'd5, 8'h08, 2}, '{0, 1, 8'd1, 4'd5, 8'h08, 4}, 0);
      // two faults, first retained
      march(0, 3, 8'h01, 9, 8'h80, 1);
      finish_test('{0, 1, 8'd2, 4'd3, 8'h01, 2}, '{0, 1, 8'd2, 4'd3, 8'h01, 4}, 0);
      // five faults: ERR_W=2 instance saturates at 3
      for (int a = 0; a < 5; a++) drive(1, 4'(a), 1, 8'h00, a == 0, 0);
      finish_test('{0, 1, 8'd5, 4'd0, 8'hFF, 2}, '{0, 1, 8'd3, 4'd0, 8'hFF, 4}, 0);
      // corrupted last read issued together with test_end
      for (int a = 0; a < 15; a++) drive(1, 4'(a), 1, 8'hFF, a == 0, 0);
      drive(1, 4'd15, 1, 8'h7F, 0, 1);
      finish_test('{0, 1, 8'd1, 4'd15, 8'h80, 2}, '{0, 1, 8'd1, 4'd15, 8'h80, 4}, 1);
      // start with test_end from DONE: results clear, start wins over test_end
      drive(0, 0, 0, 8'h00, 1, 1);
      drive(0, 0, 0, 8'h00, 0, 0);
      chk_clear("restart");
      idle(8);
      chk("start_wins_a", done_a, 0);
      chk("start_wins_c", done_c, 0);
      // mid-CHECK errors then async reset
      drive(1, 4'd2, 1, 8'h00, 0, 0);
      drive(1, 4'd3, 1, 8'h00, 0, 0);
      idle(4);
      chk("pre_reset_err_a", err_a, 2);
      @(posedge clk);
      #2 rst_n = 0;
      #1 chk_clear("async_reset");
      @(posedge clk);
      #1 rst_n = 1;
      drive(1, 4'd6, 1, 8'h00, 0, 0);
      idle(6);
      chk_clear("no_start_after_reset");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
